cplx_calc_param: RTL and testbench

//  Parametrised serial complex-number calculator. Takes a 4-word frame A,B,C,D: X=A+jB, Y=C+jD.

---
 rtl/cplx_pkg.sv | 28 ++
 rtl/cplx_mac.sv | 18 +
 rtl/cplx_calc_param.sv | 212 +++++++++++++++++++++
 tb/tb_cplx_calc_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// Shared definitions for the serial complex calculator: mode codes, FSM state
// encodings and the per-mode calculation latency.
package cplx_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_MUL  = 2'd2,
        MODE_CMUL = 2'd3
    } cplx_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INPUT = 2'd1,
        S_CALC  = 2'd2,
        S_OUT   = 2'd3
    } cplx_state_e;

    // Cycles spent in CALC: one MAC pass per result word for add/sub; a full
    // complex multiply needs four products, spread over the available MACs.
    function automatic int calc_len(input cplx_mode_e mode, input int n_mac);
        if (mode == MODE_ADD || mode == MODE_SUB) begin
            return 2;
        end
        return (n_mac == 1) ? 4 : 2;
    endfunction

endpackage

// File: rtl/cplx_mac.sv
// Combinational signed multiply-accumulate: acc_o = c_i + a_i * b_i.
module cplx_mac #(
    parameter int AW = 9,
    parameter int CW = 17
) (
    input  logic signed [AW-1:0] a_i,
    input  logic signed [AW-1:0] b_i,
    input  logic signed [CW-1:0] c_i,
    output logic signed [CW-1:0] acc_o
);

    logic signed [2*AW-1:0] prod;

    assign prod  = a_i * b_i;
    // Operands never exceed 2^(AW-2) in magnitude, so the product fits CW bits.
    assign acc_o = c_i + CW'(prod);

endmodule

// File: rtl/cplx_calc_param.sv
// Serial complex calculator: receives A,B,C,D, computes X+Y, X-Y, X*Y or
// X*conj(Y) on N_MAC shared MACs and returns the real then imaginary word.
module cplx_calc_param
    import cplx_pkg::*;
#(
    parameter int DW    = 8,
    parameter int OW    = 2*DW+1,
    parameter int N_MAC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 IN_VALID,
    input  logic [1:0]           MODE,
    input  logic signed [DW-1:0] IN,
    output logic                 BUSY,
    output logic                 OUT_VALID,
    output logic signed [OW-1:0] OUT,
    output cplx_state_e          dbg_state_o
);

    // One extra operand bit so that negating -2^(DW-1) cannot wrap.
    localparam int AW = DW + 1;
    localparam int HI = N_MAC - 1;

    localparam logic signed [AW-1:0] POS_ONE = AW'(1);
    localparam logic signed [AW-1:0] NEG_ONE = AW'(-1);

    cplx_state_e             state_q;
    cplx_mode_e              mode_q;
    logic [1:0]              cnt_q;
    logic [1:0]              step_q;
    logic signed [DW-1:0]    a_q, b_q, c_q, d_q;
    logic signed [OW-1:0]    re_q, re_d;
    logic signed [OW-1:0]    im_q, im_d;
    logic signed [OW-1:0]    out_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic signed [AW-1:0]    a_x, b_x, c_x, d_x;
    logic signed [AW-1:0]    mac_a [N_MAC];
    logic signed [AW-1:0]    mac_b [N_MAC];
    logic signed [OW-1:0]    mac_c [N_MAC];
    logic signed [OW-1:0]    mac_r [N_MAC];
    logic                    last_step;
    logic                    is_cmul;

    assign a_x = AW'(a_q);
    assign b_x = AW'(b_q);
    assign c_x = AW'(c_q);
    assign d_x = AW'(d_q);

    assign is_cmul   = (mode_q == MODE_CMUL);
    assign last_step = (step_q == 2'(calc_len(mode_q, N_MAC) - 1));

    for (genvar g = 0; g < N_MAC; g++) begin : g_mac
        cplx_mac #(
            .AW (AW),
            .CW (OW)
        ) u_mac (
            .a_i   (mac_a[g]),
            .b_i   (mac_b[g]),
            .c_i   (mac_c[g]),
            .acc_o (mac_r[g])
        );
    end

    // Operand scheduling. Add/sub run A +/- C then B +/- D through MAC 0.
    // Multiplies build re and im from two partial products each; with one MAC
    // the four products run back to back, with two MACs re and im run in parallel.
    always_comb begin
        for (int i = 0; i < N_MAC; i++) begin
            mac_a[i] = '0;
            mac_b[i] = '0;
            mac_c[i] = '0;
        end
        re_d = re_q;
        im_d = im_q;
        if (state_q == S_CALC) begin
            if (mode_q == MODE_ADD || mode_q == MODE_SUB) begin
                mac_b[0] = (mode_q == MODE_SUB) ? NEG_ONE : POS_ONE;
                if (step_q == 2'd0) begin
                    mac_a[0] = c_x;
                    mac_c[0] = OW'(a_q);
                    re_d     = mac_r[0];
                end else begin
                    mac_a[0] = d_x;
                    mac_c[0] = OW'(b_q);
                    im_d     = mac_r[0];
                end
            end else if (N_MAC == 1) begin
                case (step_q)
                    2'd0: begin
                        mac_a[0] = a_x;
                        mac_b[0] = c_x;
                        re_d     = mac_r[0];
                    end
                    2'd1: begin
                        mac_a[0] = is_cmul ? b_x : -b_x;
                        mac_b[0] = d_x;
                        mac_c[0] = re_q;
                        re_d     = mac_r[0];
                    end
                    2'd2: begin
                        mac_a[0] = is_cmul ? -a_x : a_x;
                        mac_b[0] = d_x;
                        im_d     = mac_r[0];
                    end
                    default: begin
                        mac_a[0] = b_x;
                        mac_b[0] = c_x;
                        mac_c[0] = im_q;
                        im_d     = mac_r[0];
                    end
                endcase
            end else begin
                if (step_q == 2'd0) begin
                    mac_a[0]  = a_x;
                    mac_b[0]  = c_x;
                    mac_a[HI] = is_cmul ? -a_x : a_x;
                    mac_b[HI] = d_x;
                end else begin
                    mac_a[0]  = is_cmul ? b_x : -b_x;
                    mac_b[0]  = d_x;
                    mac_c[0]  = re_q;
                    mac_a[HI] = b_x;
                    mac_b[HI] = c_x;
                    mac_c[HI] = im_q;
                end
                re_d = mac_r[0];
                im_d = mac_r[HI];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ADD;
            cnt_q       <= '0;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            re_q        <= '0;
            im_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            re_q <= re_d;
            im_q <= im_d;
            case (state_q)
                S_IDLE: begin
                    if (IN_VALID) begin
                        a_q     <= IN;
                        mode_q  <= cplx_mode_e'(MODE);
                        cnt_q   <= 2'd1;
                        busy_q  <= 1'b1;
                        state_q <= S_INPUT;
                    end
                end
                S_INPUT: begin
                    if (!IN_VALID) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        case (cnt_q)
                            2'd1:    b_q <= IN;
                            2'd2:    c_q <= IN;
                            default: d_q <= IN;
                        endcase
                        if (cnt_q == 2'd3) begin
                            step_q  <= '0;
                            state_q <= S_CALC;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                S_CALC: begin
                    // The real word is final by the last step in every mode.
                    if (last_step) begin
                        out_q       <= re_d;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_OUT;
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                default: begin
                    if (cnt_q == 2'd0) begin
                        out_q <= im_q;
                        cnt_q <= 2'd1;
                    end else begin
                        out_q       <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign BUSY        = busy_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT         = out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cplx_calc_param.sv
// Bench for cplx_calc_param: one N_MAC=1 and one N_MAC=2 instance share the
// stimulus; each has its own expected queue with result values and cycles.
module tb_cplx_calc_param;
    import cplx_pkg::*;

    localparam int DW = 8;
    localparam int OW = 17;
    localparam int NV = 16;

    typedef struct {
        logic [1:0]           mode;
        logic signed [DW-1:0] a, b, c, d;
        logic signed [OW-1:0] re, im;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic signed [DW-1:0] in_w = '0;
    logic                 bz0, bz1, ov0, ov1;
    logic signed [OW-1:0] ow0, ow1;
    cplx_state_e          st0, st1;

    int cyc = 0;
    int chk_cnt = 0;
    int err_cnt = 0;
    int bz_lo [2] = '{1, 1};
    int bz_hi [2] = '{0, 0};

    logic [OW-1:0] exp_q0[$];
    logic [OW-1:0] exp_q1[$];
    int            cyc_q0[$];
    int            cyc_q1[$];

    vec_t vecs [NV];

    cplx_calc_param #(.DW(DW), .OW(OW), .N_MAC(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .MODE(mode), .IN(in_w),
        .BUSY(bz0), .OUT_VALID(ov0), .OUT(ow0), .dbg_state_o(st0)
    );

    cplx_calc_param #(.DW(DW), .OW(OW), .N_MAC(2)) dut_n2 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .MODE(mode), .IN(in_w),
        .BUSY(bz1), .OUT_VALID(ov1), .OUT(ow1), .dbg_state_o(st1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        err_cnt++;
        $display("FAIL timeout: bench did not complete at cyc %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

    // ---------------- reference model ----------------
    function automatic int lat(input logic [1:0] m, input int nmac);
        if (m < 2'd2) return 2;
        return (nmac == 1) ? 4 : 2;
    endfunction

    task automatic model(input int m, a, b, c, d, output int re, im);
        case (m)
            0:       begin re = a + c;         im = b + d;         end
            1:       begin re = a - c;         im = b - d;         end
            2:       begin re = a * c - b * d; im = a * d + b * c; end
            default: begin re = a * c + b * d; im = b * c - a * d; end
        endcase
    endtask

    function automatic vec_t mk(input int m, a, b, c, d, re, im);
        vec_t v;
        v.mode = 2'(m);
        v.a = DW'(a);
        v.b = DW'(b);
        v.c = DW'(c);
        v.d = DW'(d);
        v.re = OW'(re);
        v.im = OW'(im);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_exp(input int ln, input int s, input logic [1:0] m,
                            input logic signed [OW-1:0] re, im);
        int l;
        l = lat(m, ln + 1);
        if (ln == 0) begin
            exp_q0.push_back(re); cyc_q0.push_back(s + 4 + l);
            exp_q0.push_back(im); cyc_q0.push_back(s + 5 + l);
        end else begin
            exp_q1.push_back(re); cyc_q1.push_back(s + 4 + l);
            exp_q1.push_back(im); cyc_q1.push_back(s + 5 + l);
        end
    endtask

    // nw = words with IN_VALID high (4 = full frame); junk = extra IN_VALID
    // cycles after D, which land in CALC and must be ignored.
    task automatic drive_frame(input logic [1:0] m, input logic signed [DW-1:0] a, b, c, d,
                               input logic signed [OW-1:0] re, im,
                               input int nw, input int junk, output int s);
        step();
        s = cyc;
        for (int ln = 0; ln < 2; ln++) begin
            bz_lo[ln] = s + 1;
            bz_hi[ln] = (nw == 4) ? s + 5 + lat(m, ln + 1) : s + nw;
        end
        if (nw == 4) begin
            push_exp(0, s, m, re, im);
            push_exp(1, s, m, re, im);
        end
        in_valid = 1'b1;
        mode = m;
        in_w = a;
        for (int k = 1; k < 4; k++) begin
            step();
            mode = 2'($urandom_range(0, 3));
            if (k < nw) begin
                in_w = (k == 1) ? b : (k == 2) ? c : d;
            end else begin
                in_valid = 1'b0;
                in_w = DW'($urandom_range(0, 255));
            end
        end
        for (int j = 0; j < junk; j++) begin
            step();
            in_valid = 1'b1;
            in_w = DW'($urandom_range(0, 255));
        end
        step();
        in_valid = 1'b0;
        in_w = DW'($urandom_range(0, 255));
    endtask

    task automatic chk(input string nm, input int got, input int want);
        chk_cnt++;
        if (got != want) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic mon(input int ln, input logic v, input logic signed [OW-1:0] o, input logic bz);
        logic          exp_bz;
        logic [OW-1:0] ev;
        int            ec;
        bit            have;
        exp_bz = rst_n && (cyc >= bz_lo[ln]) && (cyc <= bz_hi[ln]);
        chk_cnt++;
        if (bz !== exp_bz) begin
            err_cnt++;
            $display("FAIL busy n_mac=%0d cyc=%0d: got %0b expected %0b", ln + 1, cyc, bz, exp_bz);
        end
        have = 1'b0;
        ev = '0;
        ec = 0;
        if (ln == 0 && exp_q0.size() > 0) begin
            have = 1'b1; ev = exp_q0[0]; ec = cyc_q0[0];
        end
        if (ln == 1 && exp_q1.size() > 0) begin
            have = 1'b1; ev = exp_q1[0]; ec = cyc_q1[0];
        end
        chk_cnt++;
        if (v === 1'b1) begin
            if (!have) begin
                err_cnt++;
                $display("FAIL spurious_out n_mac=%0d cyc=%0d: got OUT_VALID=1 OUT=%0d expected OUT_VALID=0",
                         ln + 1, cyc, o);
            end else begin
                if (ln == 0) begin ev = exp_q0.pop_front(); ec = cyc_q0.pop_front(); end
                else         begin ev = exp_q1.pop_front(); ec = cyc_q1.pop_front(); end
                if (o !== ev || cyc != ec) begin
                    err_cnt++;
                    $display("FAIL result n_mac=%0d: got %0d at cyc %0d expected %0d at cyc %0d",
                             ln + 1, o, cyc, $signed(ev), ec);
                end
            end
        end else begin
            if (v !== 1'b0 || o !== '0) begin
                err_cnt++;
                $display("FAIL idle_out n_mac=%0d cyc=%0d: got OUT_VALID=%b OUT=%0d expected 0/0",
                         ln + 1, cyc, v, o);
            end
            if (have && cyc >= ec) begin
                err_cnt++;
                $display("FAIL missing_out n_mac=%0d: got no OUT_VALID at cyc %0d expected %0d",
                         ln + 1, cyc, $signed(ev));
                if (ln == 0) begin ev = exp_q0.pop_front(); ec = cyc_q0.pop_front(); end
                else         begin ev = exp_q1.pop_front(); ec = cyc_q1.pop_front(); end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, ow0, bz0);
        mon(1, ov1, ow1, bz1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int s;
        int m, a, b, c, d, re, im;

        vecs[0] = mk(0,    3,   -4,    5,    7,      8,     3);
        vecs[1] = mk(1,    3,   -4,    5,    7,     -2,   -11);
        vecs[2] = mk(2, -128, -128, -128,  127,  32640,   128);
        vecs[3] = mk(3,    1,    2,    3,    4,     11,     2);
        vecs[4] = mk(0,    1,    1,    1,    1,      2,     2);
        vecs[5] = mk(2, -128, -128, -128, -128,      0, 32768);
        vecs[6] = mk(3, -128, -128, -128, -128,  32768,     0);
        vecs[7] = mk(0,  127,  127,  127,  127,    254,   254);
        vecs[8] = mk(1, -128,  127,  127, -128,   -255,   255);
        vecs[9] = mk(3,  127, -128, -128,  127, -32512,   255);
        for (int i = 10; i < NV; i++) begin
            m = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            c = int'($urandom_range(0, 255)) - 128;
            d = int'($urandom_range(0, 255)) - 128;
            model(m, a, b, c, d, re, im);
            vecs[i] = mk(m, a, b, c, d, re, im);
        end

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_state_n1", int'(st0), int'(S_IDLE));
        chk("reset_state_n2", int'(st1), int'(S_IDLE));
        chk("reset_out_n1", int'(ow0), 0);
        chk("reset_out_n2", int'(ow1), 0);

        // Back-to-back frames: each starts in the slow instance's first IDLE cycle.
        for (int i = 0; i < NV; i++) begin
            drive_frame(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                        vecs[i].re, vecs[i].im, 4, i % 3, s);
            wait_cyc(s + 5 + lat(vecs[i].mode, 1));
        end

        // Aborted frames (IN_VALID drops after 1, 2 or 3 words), then a full frame.
        for (int nw = 1; nw < 4; nw++) begin
            drive_frame(2'd2, 8'sd5, 8'sd6, 8'sd7, 8'sd8, '0, '0, nw, 0, s);
            wait_cyc(s + 12);
        end
        drive_frame(2'd0, 8'sd10, -8'sd20, 8'sd30, -8'sd40, 17'sd40, -17'sd60, 4, 0, s);
        wait_cyc(s + 9);

        // Reset pulse while both instances are computing a multiply.
        drive_frame(2'd2, -8'sd128, -8'sd128, -8'sd128, 8'sd127, 17'sd32640, 17'sd128, 4, 0, s);
        step();
        chk("pre_reset_calc_n1", int'(st0), int'(S_CALC));
        chk("pre_reset_calc_n2", int'(st1), int'(S_CALC));
        bz_hi[0] = cyc - 1;
        bz_hi[1] = cyc - 1;
        exp_q0.delete(); cyc_q0.delete();
        exp_q1.delete(); cyc_q1.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_busy_n1", int'(bz0), 0);
        chk("rst_busy_n2", int'(bz1), 0);
        chk("rst_valid_n1", int'(ov0), 0);
        chk("rst_valid_n2", int'(ov1), 0);
        chk("rst_state_n1", int'(st0), int'(S_IDLE));
        chk("rst_state_n2", int'(st1), int'(S_IDLE));
        step();
        step();
        rst_n = 1'b1;
        wait_cyc(cyc + 14);
        drive_frame(2'd3, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 17'sd11, 17'sd2, 4, 0, s);
        wait_cyc(s + 16);

        chk("leftover_expected", exp_q0.size() + exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
